// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two clients, one op every 3 cycles.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise client 0 has fixed priority.
module alu_share_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [N-1:0] a0_i,
    input  logic [N-1:0] b0_i,
    input  logic [3:0]   cmd0_i,
    input  logic [N-1:0] a1_i,
    input  logic [N-1:0] b1_i,
    input  logic [3:0]   cmd1_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_cmd_o,
    input  logic [N-1:0] alu_z_i,
    output logic [N-1:0] result_o,
    output logic         done0_o,
    output logic         done1_o,
    output logic         busy_o,
    output logic         grant_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       state_q, state_d;
    logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
    logic [3:0]   alu_cmd_q, alu_cmd_d;
    logic         grant_q, grant_d, win, take;
    assign take = state_q == IDLE && (req0_i || req1_i);
`ifdef ALU_ARB_RR_EN
    logic last_q;
    assign win = (req0_i && req1_i) ? ~last_q : req1_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= 1'b1;
        else if (take) last_q <= win;
`else
    assign win = ~req0_i;
`endif
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cmd_d = alu_cmd_q;
        result_d  = result_q;
        grant_d   = grant_q;
        if (take) begin
            state_d   = EXEC;
            alu_a_d   = win ? a1_i : a0_i;
            alu_b_d   = win ? b1_i : b0_i;
            alu_cmd_d = win ? cmd1_i : cmd0_i;
            grant_d   = win;
        end else if (state_q == EXEC) begin
            state_d  = RESP;
            result_d = alu_z_i;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cmd_q <= '0;
            result_q  <= '0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cmd_q <= alu_cmd_d;
            result_q  <= result_d;
            grant_q   <= grant_d;
        end
    assign alu_a_o   = alu_a_q;
    assign alu_b_o   = alu_b_q;
    assign alu_cmd_o = alu_cmd_q;
    assign result_o  = result_q;
    assign grant_o   = grant_q;
    assign busy_o    = state_q != IDLE;
    assign done0_o   = state_q == RESP && !grant_q;
    assign done1_o   = state_q == RESP && grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table plus corner sequences, results checked through a scoreboard.
module tb_alu_share_arbiter;
    localparam int N = 32;
    logic         clk = 1'b0, rst = 1'b1;
    logic         req0, req1, done0, done1, busy, grant;
    logic [N-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_z, result;
    logic [3:0]   cmd0, cmd1, alu_cmd;
    int           errs = 0, checks = 0;

    always #5 clk = ~clk;
    assign alu_z = alu_a ^ alu_b;

    alu_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .req1_i(req1),
        .a0_i(a0), .b0_i(b0), .cmd0_i(cmd0),
        .a1_i(a1), .b1_i(b1), .cmd1_i(cmd1),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cmd_o(alu_cmd), .alu_z_i(alu_z),
        .result_o(result), .done0_o(done0), .done1_o(done1),
        .busy_o(busy), .grant_o(grant)
    );

    typedef struct {logic c; logic [N-1:0] r;} exp_t;
    typedef struct {logic c; logic [N-1:0] a; logic [N-1:0] b; logic [3:0] cmd; logic [N-1:0] z;} vec_t;
    exp_t sb[$];
    vec_t vec[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (done0 || done1) begin
            exp_t e;
            chk("done_exclusive", {127'd0, done0 && done1}, 128'd0);
            if (sb.size() == 0) begin
                errs++;
                checks++;
                $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
            end else begin
                e = sb.pop_front();
                chk("done_client", {127'd0, done1}, {127'd0, e.c});
                chk("result", {96'd0, result}, {96'd0, e.r});
            end
        end

    task automatic drive(input logic c, input logic r, input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] cmd);
        if (c) begin req1 = r; a1 = a; b1 = b; cmd1 = cmd; end
        else begin req0 = r; a0 = a; b0 = b; cmd0 = cmd; end
    endtask

    task automatic run(input vec_t v);
        drive(v.c, 1'b1, v.a, v.b, v.cmd);
        sb.push_back('{v.c, v.z});
        @(negedge clk);
        chk("exec_busy", {127'd0, busy}, 128'd1);
        chk("exec_grant", {127'd0, grant}, {127'd0, v.c});
        chk("exec_cmd", {124'd0, alu_cmd}, {124'd0, v.cmd});
        chk("exec_ops", {64'd0, alu_a, alu_b}, {64'd0, v.a, v.b});
        @(negedge clk);
        chk("resp_done", {127'd0, v.c ? done1 : done0}, 128'd1);
        drive(v.c, 1'b0, v.a, v.b, v.cmd);
        @(negedge clk);
        chk("idle_busy", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        vec[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0F0F, 4'd13, 32'h0000_0FF0};
        vec[1] = '{1'b1, 32'hDEAD_BEEF, 32'hFFFF_0000, 4'd2,  32'h2152_BEEF};
        vec[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'd0,  32'h0000_0000};
        vec[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'd15, 32'hFFFF_FFFF};
        vec[4] = '{1'b0, 32'h1234_5678, 32'h8765_4321, 4'd7,  32'h9551_1559};
        vec[5] = '{1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 4'd1,  32'hFFFF_FFFF};
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; cmd0 = 0; cmd1 = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {alu_a, alu_b, alu_cmd, result, done0, done1, busy, grant}, 128'd0);
        rst = 0;
        for (int i = 0; i < 6; i++) run(vec[i]);

        // contention: both held for four ops
        drive(0, 1, 32'h0000_F000, 32'h0000_0F00, 4'd3);
        drive(1, 1, 32'h0000_00F0, 32'h0000_000F, 4'd4);
`ifdef ALU_ARB_RR_EN
        sb.push_back('{1'b0, 32'h0000_FF00});
        sb.push_back('{1'b1, 32'h0000_00FF});
        sb.push_back('{1'b0, 32'h0000_FF00});
        sb.push_back('{1'b1, 32'h0000_00FF});
        repeat (11) @(negedge clk);
        chk("rr_last_done1", {127'd0, done1}, 128'd1);
        req0 = 0; req1 = 0;
        @(negedge clk);
`else
        for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 32'h0000_FF00});
        repeat (8) @(negedge clk);
        chk("fixed_done0", {127'd0, done0}, 128'd1);
        req0 = 0;
        sb.push_back('{1'b1, 32'h0000_00FF});
        repeat (3) @(negedge clk);
        chk("fixed_then_done1", {127'd0, done1}, 128'd1);
        req1 = 0;
        @(negedge clk);
`endif
        chk("contention_drained", sb.size(), 128'd0);

        // late request from client 1 during client 0's EXEC
        drive(0, 1, 32'h0000_0011, 32'h0000_0022, 4'd5);
        sb.push_back('{1'b0, 32'h0000_0033});
        @(negedge clk);
        drive(1, 1, 32'h0000_0100, 32'h0000_0001, 4'd6);
        sb.push_back('{1'b1, 32'h0000_0101});
        @(negedge clk);
        chk("late_done0", {127'd0, done0}, 128'd1);
        req0 = 0;
        @(negedge clk);
        chk("late_idle", {127'd0, busy}, 128'd0);
        @(negedge clk);
        chk("late_grant", {127'd0, grant}, 128'd1);
        @(negedge clk);
        chk("late_done1", {127'd0, done1}, 128'd1);
        req1 = 0;
        @(negedge clk);

        // reset during EXEC drops the op
        drive(1, 1, 32'd104061456, 32'd10, 4'd9);
        @(negedge clk);
        chk("pre_rst_busy", {127'd0, busy}, 128'd1);
        rst = 1;
        req1 = 0;
        #1;
        chk("midop_rst_outputs", {alu_a, alu_b, alu_cmd, result, done0, done1, busy, grant}, 128'd0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        run('{1'b1, 32'd104061456, 32'd10, 4'd9, 32'd104061466});

        // back-to-back: req0 held through done0
        drive(0, 1, 32'd5, 32'd6, 4'd2);
        sb.push_back('{1'b0, 32'd3});
        repeat (2) @(negedge clk);
        chk("b2b_done_first", {127'd0, done0}, 128'd1);
        drive(0, 1, 32'd1, 32'd3, 4'd8);
        sb.push_back('{1'b0, 32'd2});
        @(negedge clk);
        chk("b2b_idle", {127'd0, busy}, 128'd0);
        @(negedge clk);
        chk("b2b_regrant", {124'd0, alu_cmd}, 128'd8);
        @(negedge clk);
        chk("b2b_done_second", {127'd0, done0}, 128'd1);
        req0 = 0;
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 128'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
